// File: rtl/boot_loader_pkg.sv
// Shared definitions for the UART boot loader: host command bytes, reply
// bytes and the controller state encoding.
package boot_loader_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_READ = 8'h52;  // 'R'
  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

  localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_HALTED  = 8'h48;  // 'H'
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDRH,
    S_ADDRL,
    S_COUNT,
    S_DATA,
    S_RDWAIT1,
    S_RDWAIT2,
    S_RDLATCH,
    S_GO,
    S_RUN,
    S_REPLY,
    S_REPLYGAP
  } state_e;

  function automatic logic is_known_cmd(input logic [7:0] b);
    return (b == CMD_LOAD) || (b == CMD_READ) || (b == CMD_GO);
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Byte-stream command parser that loads and reads program RAM over a UART,
// starts the CPU and reports back when it halts.
module boot_loader
  import boot_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       is_transmitting,
  output logic [7:0] tx_byte,
  output logic       transmit,
  output logic [8:0] waddr,
  output logic [7:0] dwrite,
  output logic       write_en,
  output logic [8:0] raddr,
  input  logic [7:0] dread,
  output logic       cpu_start,
  output logic [8:0] startaddr,
  input  logic       halted,
  output logic       running
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [8:0] addr_q, addr_d;
  logic [8:0] cnt_q, cnt_d;       // 9 bits so a count byte of 0 can mean 256
  logic [7:0] reply_q, reply_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       transmit_q, transmit_d;
  logic [8:0] waddr_q, waddr_d;
  logic [7:0] dwrite_q, dwrite_d;
  logic       write_en_q, write_en_d;
  logic [8:0] raddr_q, raddr_d;
  logic       cpu_start_q, cpu_start_d;
  logic [8:0] startaddr_q, startaddr_d;
  logic       running_q, running_d;

  // NOTE: every state register is updated with <= so all of them see the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'h00;
      addr_q      <= 9'd0;
      cnt_q       <= 9'd0;
      reply_q     <= 8'h00;
      tx_byte_q   <= 8'h00;
      transmit_q  <= 1'b0;
      waddr_q     <= 9'd0;
      dwrite_q    <= 8'h00;
      write_en_q  <= 1'b0;
      raddr_q     <= 9'd0;
      cpu_start_q <= 1'b0;
      startaddr_q <= 9'd0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      reply_q     <= reply_d;
      tx_byte_q   <= tx_byte_d;
      transmit_q  <= transmit_d;
      waddr_q     <= waddr_d;
      dwrite_q    <= dwrite_d;
      write_en_q  <= write_en_d;
      raddr_q     <= raddr_d;
      cpu_start_q <= cpu_start_d;
      startaddr_q <= startaddr_d;
      running_q   <= running_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // the decoder leaves one unassigned (which would infer a latch).
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    reply_d     = reply_q;
    tx_byte_d   = tx_byte_q;
    waddr_d     = waddr_q;
    dwrite_d    = dwrite_q;
    raddr_d     = raddr_q;
    startaddr_d = startaddr_q;
    running_d   = running_q;
    transmit_d  = 1'b0;
    write_en_d  = 1'b0;
    cpu_start_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (received) begin
          cmd_d = rx_byte;
          if (is_known_cmd(rx_byte)) begin
            state_d = S_ADDRH;
          end else begin
            reply_d = RSP_UNKNOWN;
            state_d = S_REPLY;
          end
        end
      end
      S_ADDRH: begin
        if (received) begin
          addr_d  = {rx_byte[0], addr_q[7:0]};
          state_d = S_ADDRL;
        end
      end
      S_ADDRL: begin
        if (received) begin
          addr_d = {addr_q[8], rx_byte};
          if (cmd_q == CMD_LOAD) begin
            state_d = S_COUNT;
          end else if (cmd_q == CMD_READ) begin
            raddr_d = {addr_q[8], rx_byte};
            state_d = S_RDWAIT1;
          end else begin
            startaddr_d = {addr_q[8], rx_byte};
            state_d     = S_GO;
          end
        end
      end
      S_COUNT: begin
        if (received) begin
          cnt_d   = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (received) begin
          write_en_d = 1'b1;
          waddr_d    = addr_q;
          dwrite_d   = rx_byte;
          addr_d     = addr_q + 9'd1;
          cnt_d      = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            reply_d = RSP_OK;
            state_d = S_REPLY;
          end
        end
      end
      // Two cycles of RAM read latency before dread reflects raddr.
      S_RDWAIT1: state_d = S_RDWAIT2;
      S_RDWAIT2: state_d = S_RDLATCH;
      S_RDLATCH: begin
        reply_d = dread;
        state_d = S_REPLY;
      end
      S_GO: begin
        cpu_start_d = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        running_d = 1'b1;
        if (halted) begin
          running_d = 1'b0;
          reply_d   = RSP_HALTED;
          state_d   = S_REPLY;
        end
      end
      S_REPLY: begin
        if (!is_transmitting) begin
          transmit_d = 1'b1;
          tx_byte_d  = reply_q;
          state_d    = S_REPLYGAP;
        end
      end
      // Gives the UART one cycle to raise is_transmitting before we look again.
      S_REPLYGAP: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign tx_byte   = tx_byte_q;
  assign transmit  = transmit_q;
  assign waddr     = waddr_q;
  assign dwrite    = dwrite_q;
  assign write_en  = write_en_q;
  assign raddr     = raddr_q;
  assign cpu_start = cpu_start_q;
  assign startaddr = startaddr_q;
  assign running   = running_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader with a 2-cycle-latency RAM
// model and monitors that log RAM writes, UART sends and CPU start pulses.
module tb_boot_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       received = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       is_transmitting = 1'b0;
  logic [7:0] tx_byte;
  logic       transmit;
  logic [8:0] waddr;
  logic [7:0] dwrite;
  logic       write_en;
  logic [8:0] raddr;
  logic [7:0] dread = 8'h00;
  logic       cpu_start;
  logic [8:0] startaddr;
  logic       halted = 1'b0;
  logic       running;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [512];
  logic [7:0] rd_pipe = 8'h00;

  logic [8:0] wq_addr [$];
  logic [7:0] wq_data [$];
  logic [7:0] tx_q [$];
  int         n_start = 0;

  boot_loader dut (
    .clk             (clk),
    .rst             (rst),
    .received        (received),
    .rx_byte         (rx_byte),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .waddr           (waddr),
    .dwrite          (dwrite),
    .write_en        (write_en),
    .raddr           (raddr),
    .dread           (dread),
    .cpu_start       (cpu_start),
    .startaddr       (startaddr),
    .halted          (halted),
    .running         (running)
  );

  always #5 clk = ~clk;

  // RAM: write on the edge, read data appears two edges after raddr changes.
  always @(posedge clk) begin
    rd_pipe <= mem[raddr];
    dread   <= rd_pipe;
    if (write_en) mem[waddr] <= dwrite;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (write_en) begin
      wq_addr.push_back(waddr);
      wq_data.push_back(dwrite);
    end
    if (transmit) begin
      tx_q.push_back(tx_byte);
      check("tx_while_busy", {15'd0, is_transmitting}, 16'd0);
    end
    if (cpu_start) n_start++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(1);
    received = 1'b1;
    rx_byte  = b;
    tick(1);
    received = 1'b0;
    tick(2);
  endtask

  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    tx_q.delete();
    n_start = 0;
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int k;
    k = 0;
    while (tx_q.size() == 0 && k < 200) begin
      tick(1);
      k++;
    end
    check({tag, "_count"}, 16'(tx_q.size()), 16'd1);
    if (tx_q.size() != 0) check(tag, {8'h00, tx_q.pop_front()}, {8'h00, exp});
  endtask

  task automatic expect_write(input string tag, input logic [8:0] a, input logic [7:0] d);
    if (wq_addr.size() == 0) begin
      check({tag, "_missing"}, 16'd0, 16'd1);
    end else begin
      check({tag, "_addr"}, {7'd0, wq_addr.pop_front()}, {7'd0, a});
      check({tag, "_data"}, {8'h00, wq_data.pop_front()}, {8'h00, d});
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h123] = 8'h5A;

    tick(3);
    rst = 1'b0;
    check("rst_transmit",  {15'd0, transmit},  16'd0);
    check("rst_write_en",  {15'd0, write_en},  16'd0);
    check("rst_cpu_start", {15'd0, cpu_start}, 16'd0);
    check("rst_running",   {15'd0, running},   16'd0);
    check("rst_tx_byte",   {8'h00, tx_byte},   16'h0000);
    check("rst_dwrite",    {8'h00, dwrite},    16'h0000);
    check("rst_waddr",     {7'd0, waddr},      16'h0000);
    check("rst_raddr",     {7'd0, raddr},      16'h0000);
    check("rst_startaddr", {7'd0, startaddr},  16'h0000);

    // LOAD three bytes at 0x010
    clear_logs();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    expect_tx("load_ack", 8'h4B);
    check("load_nwrites", 16'(wq_addr.size()), 16'd3);
    expect_write("load_w0", 9'h010, 8'hAA);
    expect_write("load_w1", 9'h011, 8'hBB);
    expect_write("load_w2", 9'h012, 8'hCC);

    // LOAD across the top of memory
    clear_logs();
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    expect_tx("wrap_ack", 8'h4B);
    check("wrap_nwrites", 16'(wq_addr.size()), 16'd2);
    expect_write("wrap_w0", 9'h1FF, 8'h11);
    expect_write("wrap_w1", 9'h000, 8'h22);

    // READ 0x123
    clear_logs();
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h23);
    check("read_raddr", {7'd0, raddr}, 16'h0123);
    expect_tx("read_data", 8'h5A);
    tick(20);
    check("read_once", 16'(tx_q.size()), 16'd0);

    // GO, ignored byte while running, then halt
    clear_logs();
    send_byte(8'h47); send_byte(8'h00); send_byte(8'h20);
    k = 0;
    while (!running && k < 50) begin
      tick(1);
      k++;
    end
    check("go_running",   {15'd0, running}, 16'd1);
    check("go_startaddr", {7'd0, startaddr}, 16'h0020);
    check("go_pulses",    16'(n_start), 16'd1);
    send_byte(8'h41);
    tick(5);
    check("run_no_tx",     16'(tx_q.size()), 16'd0);
    check("run_no_write",  16'(wq_addr.size()), 16'd0);
    check("run_still_on",  {15'd0, running}, 16'd1);
    halted = 1'b1;
    tick(1);
    halted = 1'b0;
    check("halt_running_off", {15'd0, running}, 16'd0);
    expect_tx("halt_reply", 8'h48);
    check("go_pulses_final", 16'(n_start), 16'd1);

    // halted outside RUN has no effect
    clear_logs();
    halted = 1'b1;
    tick(1);
    halted = 1'b0;
    tick(10);
    check("idle_halt_no_tx", 16'(tx_q.size()), 16'd0);

    // Unknown command under backpressure
    clear_logs();
    is_transmitting = 1'b1;
    send_byte(8'h99);
    tick(20);
    check("busy_no_tx", 16'(tx_q.size()), 16'd0);
    is_transmitting = 1'b0;
    expect_tx("unknown_reply", 8'h3F);
    tick(10);
    check("unknown_once", 16'(tx_q.size()), 16'd0);

    // Reset in the middle of a LOAD
    clear_logs();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h02);
    check("midload_nwrites", 16'(wq_addr.size()), 16'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midload_rst_wen", {15'd0, write_en}, 16'd0);
    tick(10);
    check("midload_no_more_writes", 16'(wq_addr.size()), 16'd2);
    check("midload_no_reply",       16'(tx_q.size()), 16'd0);
    check("midload_mem0", {8'h00, mem[0]}, 16'h0001);
    check("midload_mem1", {8'h00, mem[1]}, 16'h0002);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    expect_tx("post_rst_read", 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port received, input, 1, one-cycle pulse: rx_byte valid from UART receiver.
REQ-004 SHALL have port rx_byte, input, 8, received byte.
REQ-005 SHALL have port is_transmitting, input, 1, UART transmitter busy.
REQ-006 SHALL have port tx_byte, output, 8, byte to send.
REQ-007 SHALL have port transmit, output, 1, one-cycle send strobe.
REQ-008 SHALL have port waddr, output, 9, RAM write address.
REQ-009 SHALL have port dwrite, output, 8, RAM write data.
REQ-010 SHALL have port write_en, output, 1, one-cycle RAM write strobe.
REQ-011 SHALL have port raddr, output, 9, RAM read address.
REQ-012 SHALL have port dread, input, 8, RAM read data, valid 2 cycles after raddr is registered.
REQ-013 SHALL have port cpu_start, output, 1, one-cycle CPU start pulse.
REQ-014 SHALL have port startaddr, output, 9, CPU program entry address.
REQ-015 SHALL have port halted, input, 1, one-cycle pulse from CPU on HLT.
REQ-016 SHALL have port running, output, 1, high while CPU owns the UART.

Function
REQ-017 SHALL parse host commands as a byte stream: cmd, addr_hi (bit0 only), addr_lo, then command-specific bytes.
REQ-018 SHALL treat 'L' (0x4C) as LOAD: cmd, ah, al, count, then count data bytes; count 0 means 256.
REQ-019 SHALL write each LOAD data byte in the cycle after its received pulse: write_en=1, waddr=addr, dwrite=byte; then addr+1 modulo 512 (511 wraps to 0).
REQ-020 SHALL send 'K' (0x4B) after the last LOAD data byte is written.
REQ-021 SHALL treat 'R' (0x52) as READ: cmd, ah, al; register raddr, wait 2 cycles, latch dread, then transmit it.
REQ-022 SHALL treat 'G' (0x47) as GO: cmd, ah, al; set startaddr={ah[0],al}, pulse cpu_start one cycle, then set running=1.
REQ-023 SHALL, while running=1, ignore received and hold transmit=0; running SHALL fall the cycle after halted=1, after which the block SHALL send 'H' (0x48).
REQ-024 SHALL answer any other cmd byte with '?' (0x3F) and return to IDLE.
REQ-025 SHALL assert transmit only in a cycle where is_transmitting=0, and SHALL then wait at least one idle cycle before sampling is_transmitting again; while a reply is pending, it SHALL stall (received bytes are dropped).
REQ-026 SHALL use FSM states IDLE, ADDRH, ADDRL, COUNT, DATA, RDWAIT1, RDWAIT2, RDLATCH, GO, RUN, REPLY, REPLYGAP.
REQ-027 SHALL pulse write_en, transmit and cpu_start for exactly one cycle; their default value is 0 every cycle.
REQ-028 SHALL ignore halted unless in RUN.

Reset
REQ-029 SHALL on rst: state=IDLE; transmit, write_en, cpu_start, running=0; tx_byte, dwrite=0x00; waddr, raddr, startaddr=0.
REQ-030 SHALL, on rst mid-LOAD or mid-RUN, abandon the command without reply, leaving RAM contents unchanged beyond bytes already written.

Structure
REQ-031 SHALL place the command/reply byte constants and the FSM state encoding in shared package boot_loader_pkg.
REQ-032 SHALL be a single FSM module with no sub-module; the address counter and byte counter SHALL be local registers.

Verification
REQ-033 SHALL test LOAD: rx 4C 00 10 03 AA BB CC -> writes 0x010=AA, 0x011=BB, 0x012=CC, then tx 4B.
REQ-034 SHALL test wrap: rx 4C 01 FF 02 11 22 -> writes 0x1FF=11, 0x000=22, then tx 4B.
REQ-035 SHALL test READ: RAM[0x123]=5A; rx 52 01 23 -> raddr=0x123, tx 5A exactly once.
REQ-036 SHALL test GO: rx 47 00 20 -> startaddr=0x020, one cpu_start pulse, running=1; rx 41 during RUN is ignored; halted pulse -> running=0, then tx 48.
REQ-037 SHALL test unknown command and backpressure: is_transmitting held 1, rx 99 -> no transmit until is_transmitting=0, then a single tx 3F.
REQ-038 SHALL test reset mid-LOAD: rx 4C 00 00 05 01 02, then rst -> no further writes, no reply, IDLE; next rx 52 00 01 -> tx 02.
